is_uart_tx_ctrl: RTL and testbench
==================================

Name: is_uart_tx_ctrl

Overview:
UART transmit frame sequencer. Accepts a data word over a valid/ready handshake and serialises it on tx_o as: start bit, DATA_W data bits LSB first, optional parity bit, then 1 or 2 stop bits. Bit timing comes from the TX sample counter: one tx_ce_i pulse per bit period. The block drives that counter's synchronous clear (txct_r_o) so that every frame starts on a fresh bit boundary.

Parameters:
DATA_W, 8, data bits per frame (5..9).

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
tx_ce_i  in  1  bit-period strobe from the TX sample counter; one clk wide; marks the end of the current bit
txct_r_o  out  1  synchronous clear to the TX sample counter
s_data_i  in  DATA_W  word to transmit
s_valid_i  in  1  s_data_i valid
s_ready_o  out  1  block can accept a word
parity_en_i  in  1  parity bit is appended to the frame
parity_odd_i  in  1  1 = odd parity, 0 = even parity
stop2_i  in  1  1 = two stop bits, 0 = one stop bit
tx_o  out  1  serial line, idles high
busy_o  out  1  frame in progress
done_o  out  1  one-clk pulse when the frame's last stop bit completes

Behaviour:
- Reset: rstn_i is asynchronous and active-low; clock is clk_i. Reset forces state IDLE, tx_o=1, txct_r_o=1, s_ready_o=1, busy_o=0, done_o=0, and clears the bit index. Reset applied mid-frame aborts the frame with tx_o=1 immediately. No done_o pulse is produced for an aborted frame.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- All outputs are registered. s_ready_o=(state==IDLE). busy_o=~s_ready_o.
- IDLE:
  - tx_o=1 and txct_r_o=1, which holds the sample counter at 0.
  - tx_ce_i is ignored.
  - On s_valid_i & s_ready_o: latch s_data_i, parity_en_i, parity_odd_i and stop2_i into a shadow register. Next state is START.
  - Inputs changed mid-frame have no effect on the current frame.
- START:
  - tx_o=0 and txct_r_o=0 from the first START cycle, one clk after acceptance.
  - The first tx_ce_i therefore arrives one full bit period later.
  - On tx_ce_i: go to DATA with bit index 0.
- DATA:
  - tx_o=data[idx].
  - On tx_ce_i, if idx<DATA_W-1: idx++.
  - On tx_ce_i, otherwise: go to PARITY if parity is enabled, else STOP1.
- PARITY:
  - tx_o = ^data when even parity, ~^data when odd parity.
  - On tx_ce_i: go to STOP1.
- STOP1:
  - tx_o=1.
  - On tx_ce_i: go to STOP2 if stop2 is latched; otherwise go to IDLE and pulse done_o.
- STOP2:
  - tx_o=1.
  - On tx_ce_i: go to IDLE and pulse done_o.
- done_o is high in the first IDLE cycle after the frame, i.e. the same cycle s_ready_o returns high.
- Frame length is 1+DATA_W+parity_en+(1+stop2) bit periods, plus 1 clk of acceptance latency.
- Back-to-back frames: if s_valid_i is held, the next word is accepted in the first IDLE cycle. The minimum line gap is the stop bit(s) plus 1 clk of IDLE. That IDLE cycle's txct_r_o=1 re-clears the counter.
- A tx_ce_i in the same cycle as acceptance is ignored; the state is still IDLE.
- tx_ce_i is only honoured while txct_r_o=0, so a stale strobe cannot advance START early.
- Bit index width is $clog2(DATA_W). No wrap-around beyond DATA_W-1 occurs.

Test Plan:
- 8N1 frame: word 0xA5, parity_en=0, stop2=0, tx_ce_i every 8 clks -> tx_o bits 0,1,0,1,0,0,1,0,1,1 (each 8 clks). done_o pulses once, 80 clks after START entry. s_ready_o is low throughout the frame.
- Parity: word 0xA5 with parity_en=1 -> parity bit 0 when parity_odd=0, 1 when parity_odd=1. Word 0x07 with even parity -> parity bit 1.
- Two stop bits: word 0x00, stop2=1 -> tx_o low for 9 bit periods, then high for 2. done_o follows the second stop bit. busy_o drops in the same cycle.
- Back-to-back: s_valid_i held high with 0x55 then 0xAA -> second acceptance in the done_o cycle. txct_r_o=1 for exactly 1 clk between frames. Second start bit begins 1 clk after the first frame's stop bit ends.
- Mid-frame config change: toggle parity_en_i, stop2_i and s_data_i during DATA -> transmitted frame matches the values latched at acceptance.
- Reset mid-frame: assert rstn_i during bit 4 of DATA -> tx_o=1 and txct_r_o=1 asynchronously, no done_o. After release, a new word 0x3C transmits correctly.

Source files
------------

// File: rtl/is_uart_tx_ctrl.sv
// UART transmit frame sequencer: start, DATA_W data bits LSB first, optional parity, 1 or 2 stops.
// Bit timing comes from an external sample counter that this block holds in clear while idle.
module is_uart_tx_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              tx_ce_i,
  output logic              txct_r_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic              parity_en_i,
  input  logic              parity_odd_i,
  input  logic              stop2_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pen_q, pen_d;
  logic              podd_q, podd_d;
  logic              stop2_q, stop2_d;
  logic              tx_d, txct_r_d, ready_d, done_d;
  logic              ce;

  // A strobe is only meaningful once the counter has been released from clear.
  assign ce = tx_ce_i & ~txct_r_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      pen_q     <= 1'b0;
      podd_q    <= 1'b0;
      stop2_q   <= 1'b0;
      tx_o      <= 1'b1;
      txct_r_o  <= 1'b1;
      s_ready_o <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      pen_q     <= pen_d;
      podd_q    <= podd_d;
      stop2_q   <= stop2_d;
      tx_o      <= tx_d;
      txct_r_o  <= txct_r_d;
      s_ready_o <= ready_d;
      busy_o    <= ~ready_d;
      done_o    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    pen_d   = pen_q;
    podd_d  = podd_q;
    stop2_d = stop2_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s_valid_i && s_ready_o) begin
          data_d  = s_data_i;
          pen_d   = parity_en_i;
          podd_d  = parity_odd_i;
          stop2_d = stop2_i;
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (ce) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (ce) begin
          if (idx_q == IDX_LAST) begin
            state_d = pen_q ? S_PARITY : S_STOP1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (ce) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (ce) begin
          if (stop2_q) begin
            state_d = S_STOP2;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_STOP2: begin
        if (ce) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level and handshake outputs follow the state being entered so they register with it.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_d[idx_d];
      S_PARITY: tx_d = (^data_d) ^ podd_d;
      default:  tx_d = 1'b1;
    endcase
    txct_r_d = (state_d == S_IDLE);
    ready_d  = (state_d == S_IDLE);
  end

endmodule

// File: tb/tb_is_uart_tx_ctrl.sv
// Directed bench for is_uart_tx_ctrl; a local sample counter strobes tx_ce_i every 8 clks.
module tb_is_uart_tx_ctrl;

  localparam int unsigned DATA_W = 8;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              tx_ce_i;
  logic              txct_r_o;
  logic [DATA_W-1:0] s_data_i;
  logic              s_valid_i;
  logic              s_ready_o;
  logic              parity_en_i;
  logic              parity_odd_i;
  logic              stop2_i;
  logic              tx_o;
  logic              busy_o;
  logic              done_o;

  logic [2:0] cnt;
  logic       ce_force;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk_i = ~clk_i;

  // Sample counter model: held at 0 by txct_r_o, strobes at the end of each 8-clk bit.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)       cnt <= '0;
    else if (txct_r_o) cnt <= '0;
    else               cnt <= cnt + 3'd1;
  end
  assign tx_ce_i = (cnt == 3'd7) | ce_force;

  is_uart_tx_ctrl #(.DATA_W(DATA_W)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .tx_ce_i      (tx_ce_i),
    .txct_r_o     (txct_r_o),
    .s_data_i     (s_data_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .stop2_i      (stop2_i),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic start_word(input logic [7:0] d, input logic pen, input logic podd,
                            input logic s2, input logic force_ce);
    @(negedge clk_i);
    s_data_i     = d;
    parity_en_i  = pen;
    parity_odd_i = podd;
    stop2_i      = s2;
    s_valid_i    = 1'b1;
    ce_force     = force_ce;
    @(posedge clk_i);
    #1;
    ce_force = 1'b0;
  endtask

  // Called just after the accepting edge; checks every bit mid-period and the done cycle.
  task automatic watch_frame(input string name, input logic [15:0] exp_bits, input int n,
                             input bit keep_valid, input bit mid_change);
    int dones = 0;
    int rdy   = 0;
    if (!keep_valid) s_valid_i = 1'b0;
    for (int k = 0; k <= 8 * n; k++) begin
      @(negedge clk_i);
      if (mid_change && k == 24) begin
        parity_en_i  = ~parity_en_i;
        stop2_i      = ~stop2_i;
        parity_odd_i = ~parity_odd_i;
        s_data_i     = ~s_data_i;
      end
      if (k == 0) begin
        check_eq({name, " start_tx"}, 32'(tx_o), 32'd0);
        check_eq({name, " start_txct"}, 32'(txct_r_o), 32'd0);
        check_eq({name, " start_busy"}, 32'(busy_o), 32'd1);
      end
      if (k < 8 * n) begin
        if (k % 8 == 4) check_eq($sformatf("%s bit%0d", name, k / 8), 32'(tx_o), 32'(exp_bits[k/8]));
        if (done_o) dones++;
        if (s_ready_o) rdy++;
      end
      if (k == 8 * n - 1) check_eq({name, " last_stop_txct"}, 32'(txct_r_o), 32'd0);
      if (k == 8 * n) begin
        check_eq({name, " done"}, 32'(done_o), 32'd1);
        check_eq({name, " ready_back"}, 32'(s_ready_o), 32'd1);
        check_eq({name, " busy_drop"}, 32'(busy_o), 32'd0);
        check_eq({name, " gap_txct"}, 32'(txct_r_o), 32'd1);
      end
    end
    check_eq({name, " early_done"}, 32'(dones), 32'd0);
    check_eq({name, " ready_in_frame"}, 32'(rdy), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int bad_done;
    rstn_i       = 1'b0;
    s_data_i     = '0;
    s_valid_i    = 1'b0;
    parity_en_i  = 1'b0;
    parity_odd_i = 1'b0;
    stop2_i      = 1'b0;
    ce_force     = 1'b0;
    repeat (3) @(negedge clk_i);
    check_eq("rst tx", 32'(tx_o), 32'd1);
    check_eq("rst txct", 32'(txct_r_o), 32'd1);
    check_eq("rst ready", 32'(s_ready_o), 32'd1);
    check_eq("rst busy", 32'(busy_o), 32'd0);
    check_eq("rst done", 32'(done_o), 32'd0);
    rstn_i = 1'b1;

    // Strobes while idle must not move the sequencer.
    @(negedge clk_i);
    ce_force = 1'b1;
    repeat (3) @(negedge clk_i);
    check_eq("idle_ce ready", 32'(s_ready_o), 32'd1);
    check_eq("idle_ce tx", 32'(tx_o), 32'd1);
    ce_force = 1'b0;

    // 8N1 0xA5 with a strobe coinciding with acceptance.
    start_word(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    watch_frame("8n1_a5", {1'b1, 8'hA5, 1'b0}, 10, 1'b0, 1'b0);

    // Parity: 0xA5 has four ones; 0x07 has three.
    start_word(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    watch_frame("8e1_a5", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1'b0, 1'b0);
    start_word(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    watch_frame("8o1_a5", {1'b1, 1'b1, 8'hA5, 1'b0}, 11, 1'b0, 1'b0);
    start_word(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    watch_frame("8e1_07", {1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0, 1'b0);

    // Two stop bits: nine low periods then two high.
    start_word(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    watch_frame("8n2_00", {2'b11, 8'h00, 1'b0}, 11, 1'b0, 1'b0);

    // Config and data toggled during DATA must not affect the latched frame.
    start_word(8'h3A, 1'b0, 1'b0, 1'b0, 1'b0);
    watch_frame("midcfg_3a", {1'b1, 8'h3A, 1'b0}, 10, 1'b0, 1'b1);

    // Back-to-back with valid held: second word accepted in the done cycle.
    start_word(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    s_data_i = 8'hAA;
    watch_frame("b2b_55", {1'b1, 8'h55, 1'b0}, 10, 1'b1, 1'b0);
    watch_frame("b2b_aa", {1'b1, 8'hAA, 1'b0}, 10, 1'b0, 1'b0);

    // Reset during data bit 4 aborts the frame with no done pulse.
    start_word(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    s_valid_i = 1'b0;
    repeat (43) @(negedge clk_i);
    check_eq("abort pre_tx", 32'(tx_o), 32'd0);
    rstn_i = 1'b0;
    #1;
    check_eq("abort tx", 32'(tx_o), 32'd1);
    check_eq("abort txct", 32'(txct_r_o), 32'd1);
    check_eq("abort ready", 32'(s_ready_o), 32'd1);
    bad_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      if (done_o) bad_done++;
    end
    rstn_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (done_o) bad_done++;
    end
    check_eq("abort no_done", 32'(bad_done), 32'd0);
    check_eq("abort idle_tx", 32'(tx_o), 32'd1);

    start_word(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    watch_frame("post_rst_3c", {1'b1, 8'h3C, 1'b0}, 10, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
